// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_rvalid;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_rvalid;
    logic [DATA_W-1:0] req1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, req0_rvalid, req0_rdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with burst cap sharing the single-port data memory
// between the CPU (req0) and the pixel-merge accelerator (req1).
// Grants are combinational; read data comes back registered one cycle later.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic            clk,
    input logic            reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             grant0;
    logic             grant1;
    logic             below_cap;
    logic             same_owner;

    assign below_cap  = (cnt < CNT_MAX);
    assign same_owner = (state == S_OWN0 && grant0) || (state == S_OWN1 && grant1);

    // Grant selection: the owner keeps the port until it hits the burst cap
    // while the other side waits; a tie from idle goes to whoever was not last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            case (state)
                S_OWN0: begin
                    if (bus.req0_valid && (below_cap || !bus.req1_valid)) grant0 = 1'b1;
                    else if (bus.req1_valid)                              grant1 = 1'b1;
                end
                S_OWN1: begin
                    if (bus.req1_valid && (below_cap || !bus.req0_valid)) grant1 = 1'b1;
                    else if (bus.req0_valid)                              grant0 = 1'b1;
                end
                default: begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        grant0 = last;
                        grant1 = !last;
                    end else begin
                        grant0 = bus.req0_valid;
                        grant1 = bus.req1_valid;
                    end
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Memory port mux: idle bus is driven to zero so nothing stray is written.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (grant0) begin
            bus.mem_we    = bus.req0_we;
            bus.mem_addr  = bus.req0_addr;
            bus.mem_wdata = bus.req0_wdata;
        end else if (grant1) begin
            bus.mem_we    = bus.req1_we;
            bus.mem_addr  = bus.req1_addr;
            bus.mem_wdata = bus.req1_wdata;
        end
    end

    // Ownership tracking: saturating run counter; any idle cycle forgets the owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else if (grant0 || grant1) begin
            state <= grant0 ? S_OWN0 : S_OWN1;
            last  <= grant1;
            if (same_owner) cnt <= below_cap ? cnt + CNT_W'(1) : cnt;
            else            cnt <= CNT_W'(1);
        end else begin
            state <= S_IDLE;
            cnt   <= '0;
        end
    end

    // Read responses: capture memory data on an accepted read; rdata holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.req0_rvalid <= 1'b0;
            bus.req0_rdata  <= '0;
            bus.req1_rvalid <= 1'b0;
            bus.req1_rdata  <= '0;
        end else begin
            bus.req0_rvalid <= grant0 && !bus.req0_we;
            bus.req1_rvalid <= grant1 && !bus.req1_we;
            if (grant0 && !bus.req0_we) bus.req0_rdata <= bus.mem_rdata;
            if (grant1 && !bus.req1_we) bus.req1_rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a grant-history reference model plus a word memory,
// checked every cycle, with directed scenarios and randomized traffic.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [31:0] dmem [64];
    logic [31:0] mmem [64];
    assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];

    int n_chk = 0;
    int n_pass = 0;

    // reference model state: who was granted at the previous edge (-1 none),
    // length of that requester's unbroken run, and the most recent grantee
    int m_prev = -1;
    int m_streak = 0;
    int m_last = 1;
    bit m_acc0 = 0;
    bit m_acc1 = 0;
    bit exp_rvalid [2];
    logic [31:0] exp_rdata [2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    endtask

    function automatic int exp_grant(input logic a0, input logic a1);
        if (!a0 && !a1) return -1;
        if (m_prev < 0) begin
            if (a0 && a1) return (m_last == 1) ? 0 : 1;
            return a0 ? 0 : 1;
        end
        if (m_prev == 0) begin
            if (a0 && (m_streak < MB || !a1)) return 0;
            return a1 ? 1 : -1;
        end
        if (a1 && (m_streak < MB || !a0)) return 1;
        return a0 ? 0 : -1;
    endfunction

    // compare process: model prediction vs DUT every cycle, model advance at the edge
    initial begin
        int eg;
        logic ew;
        logic [31:0] ea, ed;
        for (int i = 0; i < 64; i++) begin
            dmem[i] = $urandom;
            mmem[i] = dmem[i];
        end
        exp_rvalid[0] = 0; exp_rvalid[1] = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        forever begin
            @(negedge clk);
            #2;
            eg = -1; ew = 0; ea = '0; ed = '0;
            if (reset) begin
                m_prev = -1; m_streak = 0; m_last = 1;
                exp_rvalid[0] = 0; exp_rvalid[1] = 0;
                exp_rdata[0] = '0; exp_rdata[1] = '0;
            end else begin
                eg = exp_grant(bus.req0_valid, bus.req1_valid);
                if (eg == 0) begin ew = bus.req0_we; ea = bus.req0_addr; ed = bus.req0_wdata; end
                if (eg == 1) begin ew = bus.req1_we; ea = bus.req1_addr; ed = bus.req1_wdata; end
            end
            chk("ready0", 32'(bus.req0_ready), 32'(eg == 0));
            chk("ready1", 32'(bus.req1_ready), 32'(eg == 1));
            chk("mem_we", 32'(bus.mem_we), 32'(ew));
            chk("mem_addr", bus.mem_addr, ea);
            chk("mem_wdata", bus.mem_wdata, ed);
            chk("rvalid0", 32'(bus.req0_rvalid), 32'(exp_rvalid[0]));
            chk("rvalid1", 32'(bus.req1_rvalid), 32'(exp_rvalid[1]));
            chk("rdata0", bus.req0_rdata, exp_rdata[0]);
            chk("rdata1", bus.req1_rdata, exp_rdata[1]);
            @(posedge clk);
            if (bus.mem_we) dmem[bus.mem_addr[7:2]] = bus.mem_wdata;
            exp_rvalid[0] = 0; exp_rvalid[1] = 0;
            m_acc0 = 0; m_acc1 = 0;
            if (reset) begin
                m_prev = -1; m_streak = 0; m_last = 1;
                exp_rdata[0] = '0; exp_rdata[1] = '0;
            end else if (eg >= 0) begin
                m_streak = (eg == m_prev) ? ((m_streak < MB) ? m_streak + 1 : MB) : 1;
                m_prev = eg;
                m_last = eg;
                if (eg == 0) m_acc0 = 1; else m_acc1 = 1;
                if (ew) mmem[ea[7:2]] = ed;
                else begin
                    exp_rvalid[eg] = 1;
                    exp_rdata[eg] = mmem[ea[7:2]];
                end
            end else begin
                m_prev = -1; m_streak = 0;
            end
        end
    end

    task automatic drv(input int k, input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (k == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    task automatic idle_both();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
    endtask

    task automatic rand_txn(input int k, input int pct);
        if ($urandom_range(99) < pct)
            drv(k, 1, 1'($urandom_range(1)), {26'd0, 4'($urandom_range(15)), 2'b00}, $urandom);
        else
            drv(k, 0, 0, 0, 0);
    endtask

    task automatic rand_phase(input int n, input int p0, input int p1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!bus.req0_valid || m_acc0) rand_txn(0, p0);
            if (!bus.req1_valid || m_acc1) rand_txn(1, p1);
        end
    endtask

    // stimulus: directed scenarios with hand-computed expectations, then random traffic
    initial begin
        int exp2 [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
        reset = 1'b1;
        idle_both();
        #3;
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_rvalid0", 32'(bus.req0_rvalid), 0);
        chk("rst_rdata1", bus.req1_rdata, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // req0 write then read back
        @(negedge clk); drv(0, 1, 1, 32'h10, 32'hDEADBEEF); #3;
        chk("t1_ready0", 32'(bus.req0_ready), 1);
        chk("t1_mem_we", 32'(bus.mem_we), 1);
        chk("t1_mem_addr", bus.mem_addr, 32'h10);
        @(negedge clk); drv(0, 1, 0, 32'h10, 0); #3;
        chk("t1_rd_ready0", 32'(bus.req0_ready), 1);
        chk("t1_rd_mem_we", 32'(bus.mem_we), 0);
        @(negedge clk); drv(0, 0, 0, 0, 0); #3;
        chk("t1_rvalid0", 32'(bus.req0_rvalid), 1);
        chk("t1_rdata0", bus.req0_rdata, 32'hDEADBEEF);
        chk("t1_rvalid1", 32'(bus.req1_rvalid), 0);

        // idle ties alternate on last grantee
        @(negedge clk); drv(0, 1, 0, 32'h40, 0); drv(1, 1, 0, 32'h44, 0); #3;
        chk("t4_tie_after0_r1", 32'(bus.req1_ready), 1);
        chk("t4_tie_after0_r0", 32'(bus.req0_ready), 0);
        @(negedge clk); drv(1, 0, 0, 0, 0); #3;
        chk("t4_r0_follow", 32'(bus.req0_ready), 1);
        @(negedge clk); idle_both();
        @(negedge clk); drv(1, 1, 1, 32'h48, 32'h5A5A5A5A);
        @(negedge clk); idle_both();
        @(negedge clk); drv(0, 1, 0, 32'h40, 0); drv(1, 1, 0, 32'h44, 0); #3;
        chk("t4_tie_after1_r0", 32'(bus.req0_ready), 1);
        chk("t4_tie_after1_r1", 32'(bus.req1_ready), 0);
        @(negedge clk); drv(0, 0, 0, 0, 0);
        @(negedge clk); idle_both();

        // read followed by write to same word: rdata keeps the old value
        @(negedge clk); drv(0, 1, 1, 32'h20, 32'h12345678);
        @(negedge clk); drv(0, 1, 0, 32'h20, 0);
        @(negedge clk); drv(0, 1, 1, 32'h20, 32'h0); #3;
        chk("t6_rvalid0_n1", 32'(bus.req0_rvalid), 1);
        chk("t6_rdata0_n1", bus.req0_rdata, 32'h12345678);
        @(negedge clk); idle_both(); #3;
        chk("t6_rvalid0_n2", 32'(bus.req0_rvalid), 0);
        chk("t6_rdata0_n2", bus.req0_rdata, 32'h12345678);

        // both valid continuously from reset: burst-capped round robin
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        drv(0, 1, 0, 32'h80, 0); drv(1, 1, 0, 32'h84, 0);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            chk($sformatf("t2_grant%0d", i), 32'(bus.req1_ready), 32'(exp2[i]));
            chk($sformatf("t2_onehot%0d", i), 32'(bus.req0_ready ^ bus.req1_ready), 1);
            chk($sformatf("t2_addr%0d", i), bus.mem_addr, exp2[i] == 1 ? 32'h84 : 32'h80);
            if (i == 11) begin @(negedge clk); drv(0, 0, 0, 0, 0); #3;
                chk("t2_tail_r1", 32'(bus.req1_ready), 1); break; end
        end

        // req1 alone: granted every cycle past the burst cap
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); drv(1, 1, 1, {26'd0, 4'(i), 2'b00}, 32'hA000_0000 + 32'(i)); #3;
            chk($sformatf("t3_ready1_%0d", i), 32'(bus.req1_ready), 1);
        end
        @(negedge clk); idle_both();

        // reset between edges during a req1 burst
        @(negedge clk); drv(1, 1, 1, 32'h04, 32'h11111111);
        @(negedge clk); drv(1, 1, 1, 32'h08, 32'h22222222);
        @(negedge clk); drv(1, 1, 0, 32'h04, 0);
        @(negedge clk); drv(1, 1, 1, 32'h0C, 32'h33333333); reset = 1'b1; #3;
        chk("t5_ready1", 32'(bus.req1_ready), 0);
        chk("t5_mem_we", 32'(bus.mem_we), 0);
        chk("t5_rvalid1", 32'(bus.req1_rvalid), 0);
        chk("t5_rvalid0", 32'(bus.req0_rvalid), 0);
        @(negedge clk); reset = 1'b0; drv(0, 1, 0, 32'h30, 0); #3;
        chk("t5_first_r0", 32'(bus.req0_ready), 1);
        chk("t5_first_r1", 32'(bus.req1_ready), 0);
        chk("t5_no_rvalid1", 32'(bus.req1_rvalid), 0);
        @(negedge clk); drv(0, 0, 0, 0, 0);
        @(negedge clk); idle_both();

        rand_phase(300, 90, 90);
        rand_phase(300, 40, 40);
        rand_phase(200, 80, 20);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; idle_both();
        rand_phase(200, 95, 95);
        @(negedge clk); idle_both();
        @(negedge clk); @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
